// File: rtl/uart_pkg.sv
// Shared UART frame constants, transmit state encoding and the parity helper.
// The transmitter and the far-end receiver both import this package.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Even parity: data plus this bit always holds an even number of ones.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: the first requester searching upward from rr_ptr+1 (with wrap)
// wins. Grant is one-hot and is suppressed while enable is low.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic found;
    int   idx;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    assign any_valid = |req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = enable && found && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line between NUM_REQ byte producers: round-robin arbitration,
// then an 11-bit start/8 data/even-parity/stop frame at CLKS_PER_BIT clocks per bit.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16,
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_line,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_W - 1);

    uart_tx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]       baud_cnt_reg, baud_cnt_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [UART_DATA_W-1:0] shift_reg;
    logic                   parity_reg;
    logic [IDX_W-1:0]       rr_ptr_reg, grant_id_reg;
    logic                   tx_line_reg, busy_reg, frame_done_reg;
    logic                   tx_next;

    logic [UART_DATA_W-1:0] req_byte [NUM_REQ];
    logic [NUM_REQ-1:0]     grant_vec;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_valid;
    logic                   accept;
    logic                   bit_end;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_byte[gi] = req_data[UART_DATA_W*gi +: UART_DATA_W];
        end
    endgenerate

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .enable    ((state_reg == IDLE) && !reset),
        .grant     (grant_vec),
        .grant_idx (win_idx),
        .any_valid (any_valid)
    );

    assign accept  = (state_reg == IDLE) && any_valid;
    assign bit_end = (baud_cnt_reg == CNT_LAST);

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = bit_end ? '0 : baud_cnt_reg + CNT_W'(1);
        bit_idx_next  = bit_idx_reg;
        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                if (any_valid) begin
                    state_next   = START;
                    bit_idx_next = '0;
                end
            end
            START:  if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == BIT_LAST) begin
                        state_next   = PARITY;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            PARITY: if (bit_end) state_next = STOP;
            STOP:   if (bit_end) state_next = IDLE;
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
            end
        endcase
    end

    // The line is driven from the next state so every serial output is a flop.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[bit_idx_next];
            PARITY:  tx_next = parity_reg;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            rr_ptr_reg     <= IDX_W'(NUM_REQ - 1);
            grant_id_reg   <= '0;
            tx_line_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_cnt_reg   <= baud_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            tx_line_reg    <= tx_next;
            busy_reg       <= (state_next != IDLE);
            frame_done_reg <= (state_next == STOP) && (baud_cnt_next == CNT_LAST);
            if (accept) begin
                shift_reg    <= req_byte[win_idx];
                parity_reg   <= even_parity(req_byte[win_idx]);
                rr_ptr_reg   <= win_idx;
                grant_id_reg <= win_idx;
            end
        end
    end

    assign req_ready  = grant_vec;
    assign tx_line    = tx_line_reg;
    assign busy       = busy_reg;
    assign grant_id   = grant_id_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one UART transmit line between NUM_REQ byte producers. Arbitrates round-robin and serializes each granted byte as one 8-bit, even-parity frame at a fixed baud divisor. Sits in front of the pin that feeds the far-end even-parity 8-bit UART receiver, so several on-chip sources can report over a single serial link.

## Interface
- NUM_REQ, 4: number of requesters; must be ≥ 1.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥ 2.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept pulse; at most one bit high per cycle.
- tx_line  out  1  serial output; idle high.
- busy  out  1  high while a frame is in progress (START..STOP).
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the last accepted requester; holds between frames.
- frame_done  out  1  single-cycle pulse in the last cycle of STOP.

## Operation
- Frame format, LSB first: start (0), d[0]..d[7], parity, stop (1). 11 bits total. Parity = ^d, so the count of ones over data plus parity is even.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_line=1. If any req_valid is high, pick the first valid index searching upward from rr_ptr+1, wrapping at NUM_REQ-1 → 0. Then:
  - pulse req_ready for that index only;
  - latch the byte into shift_reg and compute parity;
  - update grant_id and rr_ptr to the winner;
  - go to START.
- Acceptance occurs when req_valid and req_ready are both high in the same cycle. Requesters must hold req_data stable while valid. The byte is captured on the accept edge, so later changes to req_data do not affect the frame in flight.
- START: tx_line=0 for CLKS_PER_BIT cycles → DATA, with bit_idx=0.
- DATA: tx_line=shift_reg[bit_idx] for CLKS_PER_BIT cycles per bit. After bit_idx=7 → PARITY.
- PARITY: tx_line=parity for CLKS_PER_BIT cycles → STOP.
- STOP: tx_line=1 for CLKS_PER_BIT cycles. frame_done is high in the last of them. Then → IDLE.
- A req_valid that drops in IDLE before it is granted is simply not served. No request queueing beyond the requester's own valid.
- A requester that keeps valid high is re-eligible only after every other valid requester has been served once (strict round-robin).
- Reset values: state=IDLE, tx_line=1, req_ready=0, busy=0, grant_id=0, frame_done=0, baud_cnt=0, bit_idx=0. rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame aborts the frame. tx_line is high from the cycle after reset is sampled, and no frame_done is produced.
- NUM_REQ=1: the arbiter degenerates to a pass-through and grant_id stays 0.

## Timing
- Accept in cycle T (IDLE, req_ready high). tx_line falls at T+1; busy rises at T+1.
- Each bit lasts exactly CLKS_PER_BIT cycles; the frame occupies T+1 .. T+11·CLKS_PER_BIT.
- frame_done is high in cycle T+11·CLKS_PER_BIT; the FSM is in IDLE at the next cycle.
- Back-to-back frames leave exactly one IDLE cycle (line high) between the stop bit and the next start bit. Stop-to-stop spacing is therefore 11·CLKS_PER_BIT+1 cycles.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary. Its width is $clog2(CLKS_PER_BIT).
- Outputs are registered; no combinational path from req_valid to tx_line.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W=8 and UART_FRAME_BITS=11;
  - state enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - even-parity function.
- The receiver must use the same package for the frame constants.
- Sub-module uart_rr_arbiter, parameterized by NUM_REQ:
  - inputs: req vector, rr_ptr, enable;
  - outputs: one-hot grant, grant index, any_valid.
- The FSM, baud counter and shift register stay in the top module.

## Test plan
- CLKS_PER_BIT=4, NUM_REQ=4, only requester 2 sends 0xA5:
  - req_ready[2] pulses once;
  - tx_line = 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (parity 0);
  - frame_done at accept+44; grant_id=2.
- Requester 0 sends 0x07 → parity bit 1; total ones over data plus parity = 4.
- All four valid from reset release, held high:
  - grant order 0,1,2,3,0;
  - one idle-high cycle between frames; stop-to-stop spacing 45 cycles.
- Requesters 1 and 3 always valid, last grant=1 → next grant 3, then 1. Requester 0 raising valid while 3 transmits is served before 1.
- Reset asserted mid-DATA of 0xFF:
  - tx_line=1 the cycle after reset is sampled; busy=0; req_ready=0; no frame_done;
  - next frame after release grants requester 0 first.
- req_data changed right after accept (0x3C → 0xC3) → the line still carries 0x3C with parity 0.
